fetch: RTL and testbench

- Instruction fetch stage of the RV32I core; the front end of the next-PC interface driven by the execute stage.
- Holds the architectural PC and fetches one instruction word from instruction memory through a req/ready/rvalid handshake.
- Presents the instruction and its PC to decode, then waits for execute to return pc_next before fetching again (single-issue, non-pipelined).
- Detects misaligned redirect targets and instruction-memory response timeouts, and reports them as a sticky fault.

---
 rtl/fetch_pkg.sv | 26 ++
 rtl/fetch.sv | 127 ++++++++++++
 tb/tb_fetch.sv | 210 +++++++++++++++++++++
 3 files changed

// File: rtl/fetch_pkg.sv
// Shared types and constants for the RV32I instruction fetch stage.
package fetch_pkg;

    localparam int unsigned XLEN = 32;

    typedef enum logic [2:0] {
        S_RESET = 3'd0,
        S_REQ   = 3'd1,
        S_WAIT  = 3'd2,
        S_HOLD  = 3'd3,
        S_FAULT = 3'd4
    } fetch_state_t;

    localparam logic [1:0] FAULT_NONE     = 2'b00;
    localparam logic [1:0] FAULT_MISALIGN = 2'b01;
    localparam logic [1:0] FAULT_TIMEOUT  = 2'b10;

    localparam logic [XLEN-1:0] INST_NOP = 32'h0000_0013;

    // Instruction handed to decode together with its address.
    typedef struct packed {
        logic [XLEN-1:0] inst;
        logic [XLEN-1:0] pc;
    } fetch_pkt_t;

endpackage

// File: rtl/fetch.sv
// Single-issue instruction fetch: one imem transaction per pc_next handshake,
// with sticky misaligned-redirect and response-timeout faults.
module fetch
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int unsigned TIMEOUT  = 16,
    parameter int unsigned CNT_W    = $clog2(TIMEOUT)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [XLEN-1:0]  pc_next,
    input  logic             pc_next_valid,
    output logic             imem_req,
    output logic [XLEN-1:0]  imem_addr,
    input  logic             imem_ready,
    input  logic             imem_rvalid,
    input  logic [XLEN-1:0]  imem_rdata,
    output logic             inst_valid,
    output logic [XLEN-1:0]  inst,
    output logic [XLEN-1:0]  inst_pc,
    output logic             fault,
    output logic [1:0]       fault_cause,
    output logic [XLEN-1:0]  fault_pc
);

    fetch_state_t    state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    fetch_pkt_t      pkt_q, pkt_d;
    logic            inst_valid_q, inst_valid_d;
    logic            fault_q, fault_d;
    logic [1:0]      cause_q, cause_d;
    logic [XLEN-1:0] fault_pc_q, fault_pc_d;

    // State and datapath registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= S_RESET;
            pc_q         <= RESET_PC;
            cnt_q        <= '0;
            pkt_q        <= '{inst: INST_NOP, pc: RESET_PC};
            inst_valid_q <= 1'b0;
            fault_q      <= 1'b0;
            cause_q      <= FAULT_NONE;
            fault_pc_q   <= '0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            cnt_q        <= cnt_d;
            pkt_q        <= pkt_d;
            inst_valid_q <= inst_valid_d;
            fault_q      <= fault_d;
            cause_q      <= cause_d;
            fault_pc_q   <= fault_pc_d;
        end
    end

    // Next-state and next-register logic.
    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        cnt_d        = cnt_q;
        pkt_d        = pkt_q;
        inst_valid_d = inst_valid_q;
        fault_d      = fault_q;
        cause_d      = cause_q;
        fault_pc_d   = fault_pc_q;

        case (state_q)
            S_RESET: state_d = S_REQ;
            S_REQ: begin
                if (imem_ready) begin
                    if (imem_rvalid) begin
                        pkt_d        = '{inst: imem_rdata, pc: pc_q};
                        inst_valid_d = 1'b1;
                        state_d      = S_HOLD;
                    end else begin
                        cnt_d   = '0;
                        state_d = S_WAIT;
                    end
                end
            end
            S_WAIT: begin
                // A response on the last allowed cycle still wins over the timeout.
                if (imem_rvalid) begin
                    pkt_d        = '{inst: imem_rdata, pc: pc_q};
                    inst_valid_d = 1'b1;
                    state_d      = S_HOLD;
                end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
                    fault_d    = 1'b1;
                    cause_d    = FAULT_TIMEOUT;
                    fault_pc_d = pc_q;
                    state_d    = S_FAULT;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_HOLD: begin
                if (pc_next_valid) begin
                    inst_valid_d = 1'b0;
                    if (pc_next[1:0] == 2'b00) begin
                        pc_d    = pc_next;
                        state_d = S_REQ;
                    end else begin
                        fault_d    = 1'b1;
                        cause_d    = FAULT_MISALIGN;
                        fault_pc_d = pc_next;
                        state_d    = S_FAULT;
                    end
                end
            end
            S_FAULT: state_d = S_FAULT;
            default: state_d = S_FAULT;
        endcase
    end

    assign imem_req    = (state_q == S_REQ);
    assign imem_addr   = pc_q;
    assign inst_valid  = inst_valid_q;
    assign inst        = pkt_q.inst;
    assign inst_pc     = pkt_q.pc;
    assign fault       = fault_q;
    assign fault_cause = cause_q;
    assign fault_pc    = fault_pc_q;

endmodule

// File: tb/tb_fetch.sv
// Directed bench for fetch: instruction responses are checked by a scoreboard
// monitor; control/fault outputs are checked inline.
module tb_fetch;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] pc_next;
    logic        pc_next_valid;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        inst_valid;
    logic [31:0] inst;
    logic [31:0] inst_pc;
    logic        fault;
    logic [1:0]  fault_cause;
    logic [31:0] fault_pc;

    int n_pass  = 0;
    int n_total = 0;
    logic [63:0] exp_q[$];
    logic [63:0] mon_e;
    logic        prev_v = 1'b0;

    fetch #(.RESET_PC(32'h0000_0000), .TIMEOUT(16)) dut (
        .clk(clk), .rst(rst),
        .pc_next(pc_next), .pc_next_valid(pc_next_valid),
        .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_ready(imem_ready), .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
        .inst_valid(inst_valid), .inst(inst), .inst_pc(inst_pc),
        .fault(fault), .fault_cause(fault_cause), .fault_pc(fault_pc)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_vals();
        check("rst_inst_valid", 32'(inst_valid), 32'd0);
        check("rst_inst", inst, 32'h0000_0013);
        check("rst_inst_pc", inst_pc, 32'h0);
        check("rst_imem_req", 32'(imem_req), 32'd0);
        check("rst_fault", 32'(fault), 32'd0);
        check("rst_fault_cause", 32'(fault_cause), 32'd0);
        check("rst_fault_pc", fault_pc, 32'h0);
    endtask

    // Zero-wait fetch: caller is in S_REQ (sampled #1 after the edge).
    task automatic zero_fetch(input logic [31:0] data, input logic [31:0] pc);
        check("zf_req", 32'(imem_req), 32'd1);
        check("zf_addr", imem_addr, pc);
        imem_ready = 1'b1; imem_rvalid = 1'b1; imem_rdata = data;
        exp_q.push_back({data, pc});
        step();
        imem_ready = 1'b0; imem_rvalid = 1'b0;
        check("zf_inst_valid", 32'(inst_valid), 32'd1);
    endtask

    task automatic redirect(input logic [31:0] pc);
        pc_next = pc; pc_next_valid = 1'b1;
        step();
        pc_next_valid = 1'b0;
        check("redir_req", 32'(imem_req), 32'd1);
        check("redir_addr", imem_addr, pc);
        check("redir_inst_valid", 32'(inst_valid), 32'd0);
    endtask

    // Scoreboard monitor: one expected entry per rising edge of inst_valid.
    always @(negedge clk) begin
        if (inst_valid && !prev_v) begin
            if (exp_q.size() == 0) begin
                n_total++;
                $display("FAIL unexpected_inst: got %h at pc %h, none expected", inst, inst_pc);
            end else begin
                mon_e = exp_q.pop_front();
                check("sb_inst", inst, mon_e[63:32]);
                check("sb_inst_pc", inst_pc, mon_e[31:0]);
            end
        end
        prev_v = inst_valid;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: bench did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b0; pc_next = '0; pc_next_valid = 1'b0;
        imem_ready = 1'b0; imem_rvalid = 1'b0; imem_rdata = '0;
        repeat (2) @(posedge clk);
        #1;
        check_reset_vals();
        rst = 1'b1;
        step();

        // Reset release then zero-wait fetch of addi x1,x0,5.
        zero_fetch(32'h0050_0093, 32'h0);
        check("hold_inst_pc", inst_pc, 32'h0);

        // Redirect to 0x10, then ready held low 3 cycles.
        redirect(32'h0000_0010);
        for (int i = 0; i < 3; i++) begin
            step();
            check("stall_req", 32'(imem_req), 32'd1);
            check("stall_addr", imem_addr, 32'h10);
        end
        imem_ready = 1'b1;
        step();
        imem_ready = 1'b0;
        check("wait_req", 32'(imem_req), 32'd0);
        repeat (3) begin
            step();
            check("wait_addr", imem_addr, 32'h10);
        end
        imem_rvalid = 1'b1; imem_rdata = 32'h0010_8113;
        exp_q.push_back({32'h0010_8113, 32'h10});
        step();
        imem_rvalid = 1'b0;
        check("late_fault", 32'(fault), 32'd0);
        check("late_inst_valid", 32'(inst_valid), 32'd1);

        // Response on the last allowed WAIT cycle: no fault.
        redirect(32'h0000_0020);
        imem_ready = 1'b1;
        step();
        imem_ready = 1'b0;
        repeat (15) step();
        check("edge_fault_pre", 32'(fault), 32'd0);
        imem_rvalid = 1'b1; imem_rdata = 32'h0020_0193;
        exp_q.push_back({32'h0020_0193, 32'h20});
        step();
        imem_rvalid = 1'b0;
        check("edge_fault", 32'(fault), 32'd0);
        check("edge_inst_valid", 32'(inst_valid), 32'd1);

        // Reset in the middle of WAIT.
        redirect(32'h0000_0030);
        imem_ready = 1'b1;
        step();
        imem_ready = 1'b0;
        repeat (4) step();
        #2 rst = 1'b0;
        #1 check_reset_vals();
        check("rst_addr", imem_addr, 32'h0);
        rst = 1'b1;
        step();
        zero_fetch(32'h0000_0213, 32'h0);

        // Top-of-address-space target is legal.
        redirect(32'hFFFF_FFFC);
        zero_fetch(32'h0030_0293, 32'hFFFF_FFFC);

        // Misaligned redirect.
        pc_next = 32'h0000_0006; pc_next_valid = 1'b1;
        step();
        pc_next_valid = 1'b0;
        check("mis_fault", 32'(fault), 32'd1);
        check("mis_cause", 32'(fault_cause), 32'd1);
        check("mis_fault_pc", fault_pc, 32'h6);
        check("mis_inst_valid", 32'(inst_valid), 32'd0);
        check("mis_pc_kept", imem_addr, 32'hFFFF_FFFC);
        pc_next = 32'h0000_0040; pc_next_valid = 1'b1;
        imem_ready = 1'b1; imem_rvalid = 1'b1;
        repeat (3) step();
        pc_next_valid = 1'b0; imem_ready = 1'b0; imem_rvalid = 1'b0;
        check("mis_sticky_req", 32'(imem_req), 32'd0);
        check("mis_sticky_cause", 32'(fault_cause), 32'd1);
        check("mis_sticky_pc", fault_pc, 32'h6);
        check("mis_sticky_valid", 32'(inst_valid), 32'd0);

        // Timeout after 16 WAIT cycles with no response.
        #2 rst = 1'b0;
        #2 rst = 1'b1;
        step();
        check("to_req", 32'(imem_req), 32'd1);
        imem_ready = 1'b1;
        step();
        imem_ready = 1'b0;
        repeat (15) step();
        check("to_fault_pre", 32'(fault), 32'd0);
        step();
        check("to_fault", 32'(fault), 32'd1);
        check("to_cause", 32'(fault_cause), 32'd2);
        check("to_fault_pc", fault_pc, 32'h0);
        step();
        check("to_req_low", 32'(imem_req), 32'd0);

        @(negedge clk);
        n_total++;
        if (exp_q.size() == 0) n_pass++;
        else $display("FAIL sb_drain: got %0d pending expected 0", exp_q.size());

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
